coin_acceptor: RTL
==================

Name: coin_acceptor

Overview:
Front end that drives the coin-input side of the vending FSM. It takes three raw, asynchronous, bouncy coin-slot sensor levels and turns them into clean single-cycle N/D/Q pulses, with at most one pulse per cycle. Simultaneous coins are serialized, glitches are rejected, and coins arriving while the vending FSM is not accepting are diverted to a reject pulse.

Parameters:
DEBOUNCE, 4, consecutive synchronized-stable cycles required to accept an insertion or a release; legal range 2..15.
CNT_W, 4, debounce counter width; must hold DEBOUNCE.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
coin_n_raw  input  1  nickel slot sensor, asynchronous level
coin_d_raw  input  1  dime slot sensor, asynchronous level
coin_q_raw  input  1  quarter slot sensor, asynchronous level
accept_en  input  1  synchronous; high = vending FSM accepting coins
N  output  1  one-cycle nickel pulse to vending FSM
D  output  1  one-cycle dime pulse to vending FSM
Q  output  1  one-cycle quarter pulse to vending FSM
reject  output  1  one-cycle pulse: coin detected while accept_en low (drives return flap)

Behaviour:
- Reset (async) clears all synchronizer flops, counters, pending flags, and outputs. N, D, Q, and reject are 0 during reset.
- Each raw input passes through a 2-flop synchronizer (s1 -> s2). Only s2 is used downstream.
- Per-channel debounce FSM, states IDLE, ARMING, HELD, RELEASING:
  - IDLE: s2=1 -> ARMING with cnt=1.
  - ARMING: s2=1 -> cnt++. When cnt reaches DEBOUNCE: detect (internal, one cycle), go to HELD. s2=0 before that -> IDLE, cnt=0 (glitch dropped).
  - HELD: s2=0 -> RELEASING with cnt=1.
  - RELEASING: s2=0 -> cnt++; at DEBOUNCE -> IDLE. s2=1 -> HELD, cnt=0 (bounce on exit, no new coin).
  - Reset state is HELD with cnt=0. A coin held across reset deassertion is never counted; the channel must see DEBOUNCE low cycles before it can arm.
- Detect handling, on the same edge the detect is registered:
  - accept_en=1 -> set pending[type].
  - accept_en=0 -> reject=1 for the next cycle; pending is unchanged.
  - Several channels rejecting on the same edge produce a single one-cycle reject pulse.
- Output arbiter (registered outputs):
  - Each edge, if any pending is set, assert exactly one output for one cycle. Priority is Q > D > N. Clear that pending bit.
  - A lower-priority coin waits one cycle per higher-priority coin ahead of it.
  - N, D, Q are one-hot-or-zero in every cycle.
- Latency, uncontended: let E0 be the first edge sampling raw=1. The pulse is high in the cycle following edge E0+DEBOUNCE+2.
- A new detect on a channel whose pending bit is still set cannot occur for DEBOUNCE>=2 (minimum re-detect spacing is 2*DEBOUNCE edges; maximum arbitration wait is 2). The bench asserts this as a property.
- accept_en falling while a coin is pending: the pending coin is still delivered. Enable is sampled only at detect time.

Decomposition:
- Package coin_pkg holds:
  - coin index constants COIN_N=0, COIN_D=1, COIN_Q=2
  - debounce state encoding (2-bit)
  - default DEBOUNCE
- Sub-module coin_debounce (synchronizer + debounce FSM + counter, output detect) is instantiated three times.
- The top level holds the pending flags, reject logic, and the priority arbiter.

Test Plan:
All scenarios use DEBOUNCE=4, with accept_en=1 unless stated and ≥8 idle-low cycles after reset.
1. coin_d_raw high 10 cycles from E0 -> exactly one D pulse in the cycle after E6. N, Q, and reject stay 0 throughout.
2. coin_n_raw high 3 cycles, then low -> no pulse on any output. The channel returns to IDLE and a following 6-cycle insertion yields one N.
3. coin_n_raw, coin_d_raw, and coin_q_raw all rise on the same cycle and are held 8 cycles -> Q, D, N pulses on three consecutive cycles in that order, each exactly one cycle wide.
4. accept_en=0, coin_q_raw high 8 cycles -> reject high one cycle after E5, and no Q. Repeating with accept_en=1 -> one Q.
5. coin_d_raw held high from before reset assertion through 10 cycles after deassertion -> no D. Release for 4+ cycles, then reinsert for 6 cycles -> one D.
6. coin_q_raw pattern high 6, low 1, high 5, low 10 (exit bounce) -> exactly one Q pulse in total.

Source files
------------

// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - shared constants for the coin acceptor front end
// Contents: coin channel indices, debounce state encoding, default
// debounce length, and the fixed-priority grant helper (Q > D > N).
package coin_pkg;

   localparam int COIN_N    = 0;
   localparam int COIN_D    = 1;
   localparam int COIN_Q    = 2;
   localparam int NUM_COINS = 3;

   localparam int DEBOUNCE_DEFAULT = 4;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ARMING    = 2'd1;
   localparam logic [1:0] ST_HELD      = 2'd2;
   localparam logic [1:0] ST_RELEASING = 2'd3;

   // One-hot-or-zero grant of the highest-priority pending coin.
   function automatic logic [NUM_COINS-1:0] pick_grant(input logic [NUM_COINS-1:0] pend);
      logic [NUM_COINS-1:0] g;
      g = '0;
      if (pend[COIN_Q])      g[COIN_Q] = 1'b1;
      else if (pend[COIN_D]) g[COIN_D] = 1'b1;
      else if (pend[COIN_N]) g[COIN_N] = 1'b1;
      return g;
   endfunction

endpackage

// File: rtl/coin_debounce.sv
// rtl/coin_debounce.sv - per-slot synchronizer and debounce FSM
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous active-high reset
//   raw    - asynchronous, bouncy slot sensor level
//   detect - combinational; high in the cycle whose closing edge accepts an
//            insertion (the owner registers its effect on that same edge)
module coin_debounce
   import coin_pkg::*;
#(
   parameter int DEBOUNCE = DEBOUNCE_DEFAULT,
   parameter int CNT_W    = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic detect
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s1;
   logic             s2;
   logic [1:0]       state;
   logic [1:0]       state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // The counter never stores DEBOUNCE itself: the edge on which it would
   // reach DEBOUNCE is the edge that changes state.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      detect     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (s2) begin
               state_next = ST_ARMING;
               cnt_next   = CNT_ONE;
            end
         end
         ST_ARMING: begin
            if (!s2) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               detect     = 1'b1;
               state_next = ST_HELD;
               cnt_next   = '0;
            end else begin
               cnt_next   = cnt + CNT_ONE;
            end
         end
         ST_HELD: begin
            if (!s2) begin
               state_next = ST_RELEASING;
               cnt_next   = CNT_ONE;
            end
         end
         default: begin
            if (s2) begin
               // Bounce while the coin leaves the slot: not a new coin.
               state_next = ST_HELD;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next   = cnt + CNT_ONE;
            end
         end
      endcase
   end

   // Resetting into HELD means a coin sitting in the slot across reset is
   // never counted; the slot must first read empty for DEBOUNCE cycles.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_HELD;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin input front end for the vending FSM
// Ports:
//   clock, reset                        - clock, asynchronous active-high reset
//   coin_n_raw, coin_d_raw, coin_q_raw  - asynchronous slot sensor levels
//   accept_en                           - high while the vending FSM takes coins
//   N, D, Q                             - one-cycle coin pulses, one-hot-or-zero
//   reject                              - one-cycle pulse to open the return flap
module coin_acceptor
   import coin_pkg::*;
#(
   parameter int DEBOUNCE = DEBOUNCE_DEFAULT,
   parameter int CNT_W    = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic coin_n_raw,
   input  logic coin_d_raw,
   input  logic coin_q_raw,
   input  logic accept_en,
   output logic N,
   output logic D,
   output logic Q,
   output logic reject
);

   logic [NUM_COINS-1:0] raw;
   logic [NUM_COINS-1:0] detect;
   logic [NUM_COINS-1:0] pending;
   logic [NUM_COINS-1:0] grant;
   logic [NUM_COINS-1:0] accepted;

   assign raw[COIN_N] = coin_n_raw;
   assign raw[COIN_D] = coin_d_raw;
   assign raw[COIN_Q] = coin_q_raw;

   for (genvar c = 0; c < NUM_COINS; c++) begin : g_chan
      coin_debounce #(
         .DEBOUNCE (DEBOUNCE),
         .CNT_W    (CNT_W)
      ) u_debounce (
         .clock  (clock),
         .reset  (reset),
         .raw    (raw[c]),
         .detect (detect[c])
      );
   end

   assign grant    = pick_grant(pending);
   assign accepted = accept_en ? detect : '0;

   // A channel cannot re-detect while its own pending bit is still set, so
   // clearing the granted bit and setting new ones never collide.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending <= '0;
         N       <= 1'b0;
         D       <= 1'b0;
         Q       <= 1'b0;
         reject  <= 1'b0;
      end else begin
         pending <= (pending & ~grant) | accepted;
         N       <= grant[COIN_N];
         D       <= grant[COIN_D];
         Q       <= grant[COIN_Q];
         reject  <= (|detect) & ~accept_en;
      end
   end

endmodule
